// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor decoder:
// byte/packet FSM states, byte0 field positions, the acceleration threshold and a clamp helper.
package mouse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } byte_state_t;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } packet_state_t;

    localparam int B0_LEFT    = 0;
    localparam int B0_RIGHT   = 1;
    localparam int B0_MIDDLE  = 2;
    localparam int B0_ALWAYS1 = 3;
    localparam int B0_XSIGN   = 4;
    localparam int B0_YSIGN   = 5;
    localparam int B0_XOVF    = 6;
    localparam int B0_YOVF    = 7;

    localparam int ACCEL_THRESHOLD = 16;

    // Only the byte0 fields that matter once the packet completes; bit 3 is used for alignment only.
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] buttons;
    } byte0_fields_t;

    function automatic logic [9:0] clamp_axis(input logic signed [11:0] value, input logic [9:0] max_val);
        if (value < 12'sd0)
            return 10'd0;
        else if (value > $signed({2'b00, max_val}))
            return max_val;
        else
            return value[9:0];
    endfunction

endpackage

// File: rtl/mouse_cursor_decoder_if.sv
// PS/2 line inputs and cursor/status outputs of the mouse cursor decoder.
// The master side is the mouse/host environment, the slave side is the decoder.
interface mouse_cursor_decoder_if;

    logic              PS2_CLK;
    logic              PS2_DAT;
    logic [9:0]        BallX;
    logic [9:0]        BallY;
    logic signed [7:0] MouseButtons;
    logic              packet_valid;
    logic              frame_error;

    modport master (
        output PS2_CLK, PS2_DAT,
        input  BallX, BallY, MouseButtons, packet_valid, frame_error
    );

    modport slave (
        input  PS2_CLK, PS2_DAT,
        output BallX, BallY, MouseButtons, packet_valid, frame_error
    );

endinterface

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: line synchronisers, falling-edge detect, 11-bit frame FSM with odd parity,
// stop-bit check and inter-edge timeout. byte_valid/byte_err are single-cycle and mutually exclusive.
module ps2_byte_rx
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    byte_state_t   state;
    byte_state_t   state_next;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] timeout_cnt;
    logic          timeout_hit;
    logic          parity_ok;

    // Lines idle high, so the synchronisers reset high to avoid a false edge after reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall        = clk_prev & ~clk_sync[1];
    assign bit_in      = dat_sync[1];
    assign timeout_hit = (state != IDLE) && !fall && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign parity_ok   = ^{shift_reg, parity_bit};
    assign byte_data   = shift_reg;

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall && !bit_in) state_next = DATA;
            DATA:    if (timeout_hit) state_next = IDLE;
                     else if (fall && bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  if (timeout_hit) state_next = IDLE;
                     else if (fall) state_next = STOP;
            STOP:    if (timeout_hit || fall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        if (timeout_hit)
            byte_err = 1'b1;
        else if (state == STOP && fall) begin
            if (bit_in && parity_ok)
                byte_valid = 1'b1;
            else
                byte_err = 1'b1;
        end
    end

    // Shift register, parity capture, bit count and timeout count.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
        end else begin
            if (fall || state == IDLE || timeout_hit)
                timeout_cnt <= '0;
            else
                timeout_cnt <= timeout_cnt + 1'b1;

            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA:    begin
                                 shift_reg <= {bit_in, shift_reg[7:1]};
                                 bit_cnt   <= bit_cnt + 3'd1;
                             end
                    PARITY:  parity_bit <= bit_in;
                    default: ;
                endcase
            end

            if (timeout_hit)
                bit_cnt <= '0;
        end
    end

endmodule

// File: rtl/mouse_cursor_decoder.sv
// PS/2 mouse packet decoder that tracks a clamped cursor position and button state.
// Define MOUSE_ACCEL_EN to double any axis delta of magnitude 16 or more.
module mouse_cursor_decoder
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    mouse_cursor_decoder_if.slave   bus
);

    packet_state_t     pkt_state;
    packet_state_t     pkt_next;
    logic              byte_valid;
    logic              byte_err;
    logic [7:0]        byte_data;
    logic              store_b0;
    logic              store_b1;
    logic              commit;
    byte0_fields_t     byte0_q;
    logic [7:0]        byte1_q;
    logic [9:0]        ball_x;
    logic [9:0]        ball_y;
    logic signed [7:0] buttons;
    logic              packet_valid_q;
    logic              frame_error_q;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic signed [11:0] sum_x;
    logic signed [11:0] sum_y;

    function automatic logic signed [11:0] scale_delta(input logic signed [8:0] d);
        logic signed [11:0] wide;
        wide = {{3{d[8]}}, d};
`ifdef MOUSE_ACCEL_EN
        if (wide >= 12'sd16 || wide <= -12'sd16)
            wide = wide <<< 1;
`endif
        return wide;
    endfunction

    ps2_byte_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (bus.PS2_CLK),
        .ps2_dat    (bus.PS2_DAT),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            pkt_state <= WAIT_B0;
        else
            pkt_state <= pkt_next;
    end

    // A frame error always realigns to byte0; a byte0 without bit 3 set is dropped silently.
    always_comb begin
        pkt_next = pkt_state;
        if (byte_err)
            pkt_next = WAIT_B0;
        else if (byte_valid) begin
            case (pkt_state)
                WAIT_B0: if (byte_data[B0_ALWAYS1]) pkt_next = WAIT_B1;
                WAIT_B1: pkt_next = WAIT_B2;
                WAIT_B2: pkt_next = WAIT_B0;
                default: pkt_next = WAIT_B0;
            endcase
        end
    end

    always_comb begin
        store_b0 = byte_valid && (pkt_state == WAIT_B0) && byte_data[B0_ALWAYS1];
        store_b1 = byte_valid && (pkt_state == WAIT_B1);
        commit   = byte_valid && (pkt_state == WAIT_B2);
    end

    // 12-bit signed sums leave headroom for a doubled delta on top of the screen coordinate.
    assign dx    = {byte0_q.x_sign, byte1_q};
    assign dy    = {byte0_q.y_sign, byte_data};
    assign sum_x = $signed({2'b00, ball_x}) + scale_delta(dx);
    assign sum_y = $signed({2'b00, ball_y}) - scale_delta(dy);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            byte0_q        <= '0;
            byte1_q        <= '0;
            ball_x         <= 10'(X_INIT);
            ball_y         <= 10'(Y_INIT);
            buttons        <= '0;
            packet_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            packet_valid_q <= commit;
            frame_error_q  <= byte_err;
            if (store_b0) begin
                byte0_q.y_ovf   <= byte_data[B0_YOVF];
                byte0_q.x_ovf   <= byte_data[B0_XOVF];
                byte0_q.y_sign  <= byte_data[B0_YSIGN];
                byte0_q.x_sign  <= byte_data[B0_XSIGN];
                byte0_q.buttons <= {byte_data[B0_MIDDLE], byte_data[B0_RIGHT], byte_data[B0_LEFT]};
            end
            if (store_b1)
                byte1_q <= byte_data;
            if (commit) begin
                buttons <= {5'b00000, byte0_q.buttons};
                if (!byte0_q.x_ovf)
                    ball_x <= clamp_axis(sum_x, 10'(X_MAX));
                if (!byte0_q.y_ovf)
                    ball_y <= clamp_axis(sum_y, 10'(Y_MAX));
            end
        end
    end

    assign bus.BallX        = ball_x;
    assign bus.BallY        = ball_y;
    assign bus.MouseButtons = buttons;
    assign bus.packet_valid = packet_valid_q;
    assign bus.frame_error  = frame_error_q;

endmodule

// File: tb/tb_mouse_cursor_decoder.sv
// Self-checking bench for mouse_cursor_decoder: directed and random PS/2 packets
// compared against a cursor model built from packet arithmetic.
module tb_mouse_cursor_decoder;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 8;
    localparam int XI = 320, YI = 240, XM = 639, YM = 479;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    int assertion_count = 0;
    int failure_count   = 0;
    int pv_count = 0, fe_count = 0, overlap_count = 0;
    int exp_x = XI, exp_y = YI, exp_btn = 0, exp_pv = 0, exp_fe = 0;
    int prev_x, prev_y, step;

    always #5 Clk = ~Clk;

    mouse_cursor_decoder_if bus();

    mouse_cursor_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .X_INIT         (XI),
        .Y_INIT         (YI),
        .X_MAX          (XM),
        .Y_MAX          (YM)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Pulse monitor, sampled on the inactive clock edge.
    always @(negedge Clk) begin
        if (bus.packet_valid === 1'b1) pv_count++;
        if (bus.frame_error === 1'b1) fe_count++;
        if (bus.packet_valid === 1'b1 && bus.frame_error === 1'b1) overlap_count++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertion_count++;
        assert (observed === expected) else begin
            failure_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_x"},   32'(bus.BallX), exp_x);
        check_output({tag, "_y"},   32'(bus.BallY), exp_y);
        check_output({tag, "_btn"}, 32'(bus.MouseButtons), exp_btn);
        check_output({tag, "_pv"},  pv_count, exp_pv);
        check_output({tag, "_fe"},  fe_count, exp_fe);
    endtask

    task automatic drive_bit(input logic v);
        @(negedge Clk);
        bus.PS2_DAT = v;
        wait_cycles(HALF);
        bus.PS2_CLK = 1'b0;
        wait_cycles(HALF);
        bus.PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity, input bit bad_stop);
        logic [10:0] bits;
        logic p;
        p = (~^b) ^ bad_parity;
        bits = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i]);
        bus.PS2_DAT = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int accel(input int d);
`ifdef MOUSE_ACCEL_EN
        if (d >= 16 || d <= -16) return 2 * d;
`endif
        return d;
    endfunction

    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = int'(b1) - (b0[4] ? 256 : 0);
        dy = int'(b2) - (b0[5] ? 256 : 0);
        if (!b0[6]) exp_x = clampi(exp_x + accel(dx), XM);
        if (!b0[7]) exp_y = clampi(exp_y - accel(dy), YM);
        exp_btn = int'(b0 & 8'h07);
        exp_pv++;
    endtask

    task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 0, 0);
        send_frame(b1, 0, 0);
        send_frame(b2, 0, 0);
        model_packet(b0, b1, b2);
        wait_cycles(4);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        Reset_n = 1'b0;
        wait_cycles(3);
        Reset_n = 1'b1;
        exp_x = XI;
        exp_y = YI;
        exp_btn = 0;
        wait_cycles(2);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        int waited;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        wait_cycles(5);
        Reset_n = 1'b1;
        wait_cycles(5);
        check_state("reset");

        apply_stimulus(8'h08, 8'h05, 8'h03);
        check_state("basic");
        check_output("basic_x_lit", 32'(bus.BallX), 325);
        check_output("basic_y_lit", 32'(bus.BallY), 237);

        do_reset();
        apply_stimulus(8'h0A, 8'h00, 8'h00);
        check_state("right_btn");
        check_output("right_btn_lit", 32'(bus.MouseButtons), 2);

        repeat (3) apply_stimulus(8'h08, 8'h7F, 8'h00);
        check_state("clamp_hi");
        apply_stimulus(8'h08, 8'h20, 8'h00);
        check_output("clamp_hi_lit", 32'(bus.BallX), 639);
        repeat (6) apply_stimulus(8'h18, 8'h80, 8'h00);
        check_state("clamp_lo");
        apply_stimulus(8'h18, 8'hF0, 8'h00);
        check_output("clamp_lo_lit", 32'(bus.BallX), 0);

        send_frame(8'h08, 0, 0);
        send_frame(8'h05, 1, 0);
        wait_cycles(4);
        exp_fe++;
        check_state("parity_err");
        apply_stimulus(8'h08, 8'h03, 8'h01);
        check_state("after_parity");

        send_frame(8'h08, 0, 0);
        send_frame(8'h11, 0, 1);
        wait_cycles(4);
        exp_fe++;
        check_state("stop_err");
        apply_stimulus(8'h09, 8'h07, 8'h02);
        check_state("after_stop");

        send_frame(8'h00, 0, 0);
        wait_cycles(4);
        check_state("stray");
        apply_stimulus(8'h09, 8'h04, 8'h04);
        check_state("after_stray");

        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        bus.PS2_DAT = 1'b1;
        wait_cycles(TIMEOUT - 20);
        check_output("timeout_early", fe_count, exp_fe);
        waited = 0;
        while (fe_count == exp_fe && waited < 80) begin
            wait_cycles(1);
            waited++;
        end
        exp_fe++;
        wait_cycles(4);
        check_state("timeout");
        apply_stimulus(8'h0C, 8'h06, 8'h03);
        check_state("after_timeout");

        prev_x = exp_x;
        prev_y = exp_y;
        apply_stimulus(8'h48, 8'h7F, 8'h02);
        check_state("x_ovf");
        check_output("x_ovf_hold", 32'(bus.BallX), prev_x);
        check_output("x_ovf_y", 32'(bus.BallY), prev_y - 2);

`ifdef MOUSE_ACCEL_EN
        step = 32;
`else
        step = 16;
`endif
        prev_x = exp_x;
        apply_stimulus(8'h08, 8'h10, 8'h00);
        check_output("accel_x", 32'(bus.BallX), prev_x + step);

        send_frame(8'h08, 0, 0);
        do_reset();
        check_state("reset_mid_packet");
        apply_stimulus(8'h08, 8'h02, 8'h00);
        check_state("after_reset_packet");

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        do_reset();
        wait_cycles(TIMEOUT + 50);
        check_state("reset_mid_frame");
        apply_stimulus(8'h29, 8'h10, 8'hF0);
        check_state("after_reset_frame");

        for (int n = 0; n < 20; n++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) r0[7:6] = 2'b00;
            apply_stimulus(r0, r1, r2);
            check_state($sformatf("rand%0d", n));
        end

        check_output("overlap", overlap_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end

endmodule
